// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - per-round lives/timer/score/grace controller
// Consumes reset_is_on from the reset generator and returns gameover to it.
module game_round_ctrl #(
  parameter int LIVES_INIT  = 3,
  parameter int LIVES_MAX   = 9,
  parameter int ROUND_TICKS = 3600,
  parameter int GRACE_TICKS = 60,
  parameter int BONUS_PTS   = 100,
  parameter int TIME_W      = 12,
  parameter int SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               reset_is_on,
  input  logic               tick,
  input  logic               hit,
  input  logic               bonus,
  output logic [3:0]         lives,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] score,
  output logic               invuln,
  output logic               gameover,
  output logic               win
);

  localparam int GW = (GRACE_TICKS < 1) ? 1 : $clog2(GRACE_TICKS + 1);

  typedef enum logic [1:0] {PLAY, GRACE, OVER} state_t;

  state_t             state_q, state_d;
  logic [3:0]         lives_q, lives_d, lives_b;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;
  logic [GW-1:0]      grace_q, grace_d;
  logic               win_q, win_d;
  logic               invuln_q, gameover_q;
  logic               timeout, play_hit;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    time_d  = time_q;
    score_d = score_q;
    grace_d = grace_q;
    win_d   = win_q;

    // Bonus is applied first so a same-cycle hit sees the post-bonus life count.
    lives_b = lives_q;
    if (bonus) begin
      lives_b = (lives_q >= 4'(LIVES_MAX)) ? 4'(LIVES_MAX) : lives_q + 4'd1;
    end

    score_sum = {1'b0, score_q}
              + (tick  ? (SCORE_W+1)'(1)         : '0)
              + (bonus ? (SCORE_W+1)'(BONUS_PTS) : '0);
    timeout   = tick && (time_q == TIME_W'(1));
    play_hit  = (state_q == PLAY) && hit;

    if (state_q != OVER) begin
      lives_d = lives_b;
      score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      if (tick && (time_q != '0)) begin
        time_d = time_q - TIME_W'(1);
      end

      if (play_hit && (lives_b <= 4'd1)) begin
        lives_d = 4'd0;
        win_d   = 1'b0;
        state_d = OVER;
      end else if (timeout) begin
        if (play_hit) begin
          lives_d = lives_b - 4'd1;
        end
        win_d   = 1'b1;
        state_d = OVER;
      end else if (play_hit) begin
        lives_d = lives_b - 4'd1;
        grace_d = GW'(GRACE_TICKS);
        state_d = GRACE;
      end else if (state_q == GRACE) begin
        if (grace_q == '0) begin
          state_d = PLAY;
        end else if (tick) begin
          grace_d = grace_q - GW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_is_on) begin
      state_q    <= PLAY;
      lives_q    <= 4'(LIVES_INIT);
      time_q     <= TIME_W'(ROUND_TICKS);
      score_q    <= '0;
      grace_q    <= '0;
      win_q      <= 1'b0;
      invuln_q   <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      time_q     <= time_d;
      score_q    <= score_d;
      grace_q    <= grace_d;
      win_q      <= win_d;
      invuln_q   <= (state_d == GRACE);
      gameover_q <= (state_d == OVER);
    end
  end

  assign lives     = lives_q;
  assign time_left = time_q;
  assign score     = score_q;
  assign invuln    = invuln_q;
  assign gameover  = gameover_q;
  assign win       = win_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - scoreboard bench for game_round_ctrl
// Each scenario builds a stimulus table of hand-derived expectations.
module tb_game_round_ctrl;

  logic        clk = 1'b0;
  logic        reset_is_on = 1'b0;
  logic        tick = 1'b0;
  logic        hit = 1'b0;
  logic        bonus = 1'b0;
  logic [3:0]  lives;
  logic [11:0] time_left;
  logic [15:0] score;
  logic        invuln, gameover, win;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [3:0]  lives;
    logic [11:0] time_left;
    logic [15:0] score;
    logic        invuln;
    logic        gameover;
    logic        win;
  } snap_t;

  typedef struct {
    logic  r, t, h, b;
    snap_t e;
  } vec_t;

  typedef struct {
    string name;
    int    idx;
    snap_t e;
  } exp_t;

  exp_t sb[$];

  game_round_ctrl #(
    .LIVES_INIT(3), .LIVES_MAX(4), .ROUND_TICKS(10), .GRACE_TICKS(3),
    .BONUS_PTS(100), .TIME_W(12), .SCORE_W(16)
  ) dut (
    .clk(clk), .reset_is_on(reset_is_on), .tick(tick), .hit(hit), .bonus(bonus),
    .lives(lives), .time_left(time_left), .score(score),
    .invuln(invuln), .gameover(gameover), .win(win)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic t, logic h, logic b,
                              int l, int tl, int s, logic i, logic g, logic w);
    vec_t v;
    v.r = r; v.t = t; v.h = h; v.b = b;
    v.e.lives = 4'(l); v.e.time_left = 12'(tl); v.e.score = 16'(s);
    v.e.invuln = i; v.e.gameover = g; v.e.win = w;
    return v;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.lives = lives; s.time_left = time_left; s.score = score;
    s.invuln = invuln; s.gameover = gameover; s.win = win;
    return s;
  endfunction

  // Three grace ticks, then one idle cycle for the return to PLAY.
  function automatic void add_grace_run(inout vec_t q[$], input int l, input int t0, input int s0);
    for (int k = 1; k <= 3; k++) q.push_back(mk(0, 1, 0, 0, l, t0 - k, s0 + k, 1, 0, 0));
    q.push_back(mk(0, 0, 0, 0, l, t0 - 3, s0 + 3, 0, 0, 0));
  endfunction

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input logic r, input logic t, input logic h, input logic b);
    reset_is_on = r; tick = t; hit = h; bonus = b;
    @(posedge clk);
    @(negedge clk);
    reset_is_on = 0; tick = 0; hit = 0; bonus = 0;
  endtask

  task automatic test_reset();
    vec_t v[$];
    exp_t x;
    snap_t got;
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 1, 1, 3, 10, 0, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{"reset", i, v[i].e});
      step(v[i].r, v[i].t, v[i].h, v[i].b);
      x = sb.pop_front(); got = snap(); tests_run++;
      if (got !== x.e) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got %p expected %p", x.name, x.idx, got, x.e);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    exp_t x;
    snap_t got;
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    for (int i = 1; i <= 10; i++)
      v.push_back(mk(0, 1, 0, 0, 3, 10 - i, i, 0, i == 10, i == 10));
    v.push_back(mk(0, 1, 0, 0, 3, 0, 10, 0, 1, 1));
    v.push_back(mk(0, 1, 1, 1, 3, 0, 10, 0, 1, 1));
    foreach (v[i]) begin
      sb.push_back('{"timeout", i, v[i].e});
      step(v[i].r, v[i].t, v[i].h, v[i].b);
      x = sb.pop_front(); got = snap(); tests_run++;
      if (got !== x.e) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got %p expected %p", x.name, x.idx, got, x.e);
      end
    end
  endtask

  task automatic test_grace_and_fatal();
    vec_t v[$];
    exp_t x;
    snap_t got;
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 2, 10, 0, 1, 0, 0));
    v.push_back(mk(0, 1, 1, 0, 2, 9, 1, 1, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 2, 8, 2, 1, 0, 0));
    v.push_back(mk(0, 1, 1, 0, 2, 7, 3, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 2, 7, 3, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 1, 7, 3, 1, 0, 0));
    add_grace_run(v, 1, 7, 3);
    v.push_back(mk(0, 0, 1, 0, 0, 4, 6, 0, 1, 0));
    v.push_back(mk(0, 1, 0, 1, 0, 4, 6, 0, 1, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 4, 6, 0, 1, 0));
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{"grace_fatal", i, v[i].e});
      step(v[i].r, v[i].t, v[i].h, v[i].b);
      x = sb.pop_front(); got = snap(); tests_run++;
      if (got !== x.e) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got %p expected %p", x.name, x.idx, got, x.e);
      end
    end
  endtask

  task automatic test_bonus();
    vec_t v[$];
    exp_t x;
    snap_t got;
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 4, 10, 100, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 4, 10, 200, 0, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 2, 10, 0, 1, 0, 0));
    add_grace_run(v, 2, 10, 0);
    v.push_back(mk(0, 0, 1, 0, 1, 7, 3, 1, 0, 0));
    add_grace_run(v, 1, 7, 3);
    v.push_back(mk(0, 0, 1, 1, 1, 4, 106, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 2, 4, 206, 1, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{"bonus", i, v[i].e});
      step(v[i].r, v[i].t, v[i].h, v[i].b);
      x = sb.pop_front(); got = snap(); tests_run++;
      if (got !== x.e) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got %p expected %p", x.name, x.idx, got, x.e);
      end
    end
  endtask

  task automatic test_coincident();
    vec_t v[$];
    exp_t x;
    snap_t got;
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 2, 10, 0, 1, 0, 0));
    add_grace_run(v, 2, 10, 0);
    v.push_back(mk(0, 0, 1, 0, 1, 7, 3, 1, 0, 0));
    add_grace_run(v, 1, 7, 3);
    for (int i = 1; i <= 3; i++) v.push_back(mk(0, 1, 0, 0, 1, 4 - i, 6 + i, 0, 0, 0));
    v.push_back(mk(0, 1, 1, 0, 0, 0, 10, 0, 1, 0));
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    for (int i = 1; i <= 5; i++) v.push_back(mk(0, 1, 0, 0, 3, 10 - i, i, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 1, 4, 4, 106, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{"coincident", i, v[i].e});
      step(v[i].r, v[i].t, v[i].h, v[i].b);
      x = sb.pop_front(); got = snap(); tests_run++;
      if (got !== x.e) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got %p expected %p", x.name, x.idx, got, x.e);
      end
    end
  endtask

  task automatic test_reset_mid_grace();
    vec_t v[$];
    exp_t x;
    snap_t got;
    v.push_back(mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 2, 10, 0, 1, 0, 0));
    v.push_back(mk(0, 1, 0, 1, 3, 9, 101, 1, 0, 0));
    v.push_back(mk(1, 1, 1, 0, 3, 10, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 3, 9, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 2, 9, 1, 1, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{"reset_mid_grace", i, v[i].e});
      step(v[i].r, v[i].t, v[i].h, v[i].b);
      x = sb.pop_front(); got = snap(); tests_run++;
      if (got !== x.e) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got %p expected %p", x.name, x.idx, got, x.e);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_timeout();
    test_grace_and_fatal();
    test_bonus();
    test_coincident();
    test_reset_mid_grace();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Per-round game-state controller; sits directly downstream of the reset generator and consumes its `reset_is_on` level as its reset.
- Tracks lives, the round timer, survival score and post-hit invulnerability.
- Produces the `gameover` level that feeds back into the reset generator, closing the start/end-of-game loop.
- Timing is driven by a one-cycle frame `tick` from the display timing logic.

Parameters:
- LIVES_INIT, 3: lives loaded at reset.
- LIVES_MAX, 9: saturation ceiling for lives (4-bit field).
- ROUND_TICKS, 3600: round length in ticks (60 s at 60 Hz).
- GRACE_TICKS, 60: invulnerability length after a non-fatal hit, in ticks.
- BONUS_PTS, 100: score added per bonus pickup.
- TIME_W, 12: width of `time_left`; must hold ROUND_TICKS.
- SCORE_W, 16: width of `score`.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_is_on  in  1  synchronous, active-high reset; held high between games by the upstream reset generator.
- tick  in  1  one-cycle frame pulse; the timebase for all counters.
- hit  in  1  one-cycle collision pulse.
- bonus  in  1  one-cycle extra-life pickup pulse.
- lives  out  4  remaining lives.
- time_left  out  TIME_W  ticks remaining in the round.
- score  out  SCORE_W  current score.
- invuln  out  1  high while in GRACE.
- gameover  out  1  level; high in OVER.
- win  out  1  high in OVER when the round ended by timeout with lives > 0.

Behaviour:
- All outputs registered. Any input is reflected on outputs the cycle after the edge that samples it; no combinational input-to-output paths.
- Reset (`reset_is_on` = 1 at a rising edge) has priority over every other input and every state, including mid-GRACE and OVER. After reset:
  - state = PLAY, lives = LIVES_INIT, time_left = ROUND_TICKS, score = 0.
  - grace counter = 0, invuln = 0, gameover = 0, win = 0.
- States: PLAY, GRACE, OVER.
- PLAY, on tick:
  - time_left -= 1.
  - score += 1, saturating at all-ones.
- PLAY, on hit:
  - If lives == 1 (after applying any same-cycle bonus, see below): lives = 0, go to OVER, win = 0.
  - Otherwise: lives -= 1, grace counter = GRACE_TICKS, go to GRACE.
- GRACE:
  - tick decrements time_left and the grace counter, and increments score.
  - When the grace counter reaches 0, return to PLAY on the next cycle.
  - hit is ignored entirely.
- bonus, in PLAY or GRACE:
  - lives += 1, saturating at LIVES_MAX.
  - score += BONUS_PTS, saturating.
- hit and bonus in the same PLAY cycle:
  - Net lives change = bonus increment (saturating) − 1. Example: lives = 1 with hit+bonus gives lives = 1, no gameover.
  - The hit still enters GRACE.
  - Score gets the bonus.
- Timeout: when a tick takes time_left from 1 to 0 (in PLAY or GRACE), go to OVER with win = 1.
  - If a fatal hit occurs in the same cycle, the hit wins: win = 0, lives = 0.
  - time_left never underflows; it is clamped at 0.
- tick + bonus in the same cycle: both score increments apply (1 + BONUS_PTS), with a single saturation check.
- OVER:
  - All counters frozen.
  - gameover = 1 and win held.
  - tick, hit and bonus are ignored.
  - Exit only via reset_is_on.
- invuln = (state == GRACE); gameover = (state == OVER).
- Upstream handshake: gameover stays high until reset_is_on is asserted, and clears the cycle after reset is sampled.
- Inputs are single-cycle pulses. An input held high is treated as one event per cycle, except that hit is ignored while in GRACE.

Test Plan:
Parameters for all scenarios: ROUND_TICKS = 10, GRACE_TICKS = 3, LIVES_INIT = 3, LIVES_MAX = 4, BONUS_PTS = 100.
1. Reset then 10 ticks, no hits → after 10th tick: time_left = 0, score = 10, gameover = 1, win = 1, lives = 3; further ticks leave score = 10.
2. Hit in PLAY → next cycle lives = 2, invuln = 1. Second hit within 3 ticks → ignored, lives = 2. After 3 ticks → invuln = 0. Hit then → lives = 1.
3. From lives = 1, hit → lives = 0, gameover = 1, win = 0. Then bonus/tick → no change. Then reset_is_on = 1 for one cycle → lives = 3, time_left = 10, score = 0, gameover = 0.
4. lives = 4, bonus → lives = 4, score += 100. lives = 1, hit+bonus same cycle → lives = 1, invuln = 1, gameover = 0.
5. Tick taking time_left 1→0 coincident with fatal hit → gameover = 1, win = 0, lives = 0. Separately, tick+bonus same cycle from score = 5 → score = 106.
6. reset_is_on asserted mid-GRACE with grace counter = 2 → next cycle state = PLAY, invuln = 0, all counters at reset values. Hit and tick asserted in the same cycle as reset → no effect.
